// File: rtl/vr_pkg.sv
// Shared VeriRISC definitions: opcode and phase encodings, the phase width,
// the datapath strobe bundle and the ALU-operation membership test.
// The controller, alu and decoder benches all import this package.
package vr_pkg;

    localparam int PHASE_W = 3;
    localparam int NPHASE  = 8;

    typedef logic [2:0]         opcode_t;
    typedef logic [PHASE_W-1:0] phase_t;

    localparam opcode_t OP_HLT = 3'd0;
    localparam opcode_t OP_SKZ = 3'd1;
    localparam opcode_t OP_ADD = 3'd2;
    localparam opcode_t OP_AND = 3'd3;
    localparam opcode_t OP_XOR = 3'd4;
    localparam opcode_t OP_LDA = 3'd5;
    localparam opcode_t OP_STO = 3'd6;
    localparam opcode_t OP_JMP = 3'd7;

    localparam phase_t PH_INST_ADDR  = 3'd0;
    localparam phase_t PH_INST_FETCH = 3'd1;
    localparam phase_t PH_INST_LOAD  = 3'd2;
    localparam phase_t PH_IDLE       = 3'd3;
    localparam phase_t PH_OP_ADDR    = 3'd4;
    localparam phase_t PH_OP_FETCH   = 3'd5;
    localparam phase_t PH_ALU_OP     = 3'd6;
    localparam phase_t PH_STORE      = 3'd7;

    // Datapath strobes driven by the controller for one cycle.
    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic halt;
        logic ld_pc;
        logic data_e;
        logic ld_ac;
        logic wr;
    } strobes_t;

    // Opcodes that read an operand from memory and load the accumulator.
    function automatic logic is_aluop(input opcode_t op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Instruction phase counter: counts 0..NPHASE-1 and wraps to 0 while en=1,
// holds while en=0.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset, clears phase to 0
//   en    in  advance enable
//   phase out current phase
module phase_counter
    import vr_pkg::*;
#(
    parameter int NPHASE_P = NPHASE
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output phase_t phase
);

    localparam phase_t LAST = phase_t'(NPHASE_P - 1);

    always_ff @(posedge clk) begin
        if (rst)
            phase <= '0;
        else if (en)
            phase <= (phase == LAST) ? '0 : phase + 1'b1;
    end

endmodule

// File: rtl/controller.sv
// VeriRISC instruction sequencer. Steps an 8-phase cycle per instruction and
// decodes phase + opcode (+ zero in ALU_OP) into the datapath strobes.
// A HLT seen in OP_ADDR freezes the sequencer at OP_ADDR until rst.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   opcode        current IR opcode
//   zero          accumulator-is-zero flag (only used by SKZ in ALU_OP)
//   sel..wr       memory/IR/ACC/PC strobes, combinational from current state
//   phase         current phase (observability)
module controller
    import vr_pkg::*;
#(
    parameter int NPHASE_P = NPHASE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       halt,
    output logic       ld_pc,
    output logic       data_e,
    output logic       ld_ac,
    output logic       wr,
    output logic [2:0] phase
);

    typedef enum logic {ST_RUN, ST_HALT} ctl_state_t;

    ctl_state_t st, st_nxt;
    strobes_t   s;
    logic       cnt_en;
    logic       aluop;
    phase_t     ph;

    phase_counter #(.NPHASE_P(NPHASE_P)) u_phase (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .phase (ph)
    );

    always_ff @(posedge clk) begin
        if (rst)
            st <= ST_RUN;
        else
            st <= st_nxt;
    end

    assign aluop = is_aluop(opcode);

    always_comb begin
        st_nxt = st;
        cnt_en = 1'b0;
        s      = '0;
        unique case (st)
            ST_RUN: begin
                cnt_en = 1'b1;
                unique case (ph)
                    PH_INST_ADDR:  s.sel = 1'b1;
                    PH_INST_FETCH: begin
                        s.sel = 1'b1;
                        s.rd  = 1'b1;
                    end
                    PH_INST_LOAD, PH_IDLE: begin
                        s.sel   = 1'b1;
                        s.rd    = 1'b1;
                        s.ld_ir = 1'b1;
                    end
                    PH_OP_ADDR: begin
                        // PC still steps past the HLT itself on this cycle.
                        s.inc_pc = 1'b1;
                        s.halt   = (opcode == OP_HLT);
                    end
                    PH_OP_FETCH: s.rd = aluop;
                    PH_ALU_OP: begin
                        s.rd     = aluop;
                        s.inc_pc = (opcode == OP_SKZ) && zero;
                        s.ld_pc  = (opcode == OP_JMP);
                        s.data_e = (opcode == OP_STO);
                    end
                    PH_STORE: begin
                        s.rd     = aluop;
                        s.ld_ac  = aluop;
                        s.ld_pc  = (opcode == OP_JMP);
                        s.wr     = (opcode == OP_STO);
                        s.data_e = (opcode == OP_STO);
                    end
                endcase
                // Freeze the counter on the same edge that sets halted, so the
                // phase parks at OP_ADDR rather than moving on to OP_FETCH.
                if (ph == PH_OP_ADDR && opcode == OP_HLT) begin
                    st_nxt = ST_HALT;
                    cnt_en = 1'b0;
                end
            end
            ST_HALT: s.halt = 1'b1;
        endcase
    end

    assign sel    = s.sel;
    assign rd     = s.rd;
    assign ld_ir  = s.ld_ir;
    assign inc_pc = s.inc_pc;
    assign halt   = s.halt;
    assign ld_pc  = s.ld_pc;
    assign data_e = s.data_e;
    assign ld_ac  = s.ld_ac;
    assign wr     = s.wr;
    assign phase  = ph;

endmodule
